vin_mailbox_sequencer: RTL

//  Host-side command/transfer scheduler for the VIN video chip. Buffers CPU writes
//  (command or data, each a busA/busB byte pair) in a FIFO. Presents them to the VIN

---
 rtl/vin_mailbox_sequencer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vin_mailbox_sequencer.sv
// vin_mailbox_sequencer
// Host-side scheduler for the VIN mailbox. CPU writes (command or data, each a busA/busB
// byte pair) are queued in a FIFO. They are presented to the VIN one at a time: _ve is
// pulled low, and the VIN acknowledges by strobing _st low. A request the VIN never
// takes is aborted after TIMEOUT cycles, and the sticky err_timeout flag is raised.
//
// Ports
//   clk          system clock (same clock as the VIN)
//   _res         asynchronous active-low reset
//   host_wr      push {host_ct, host_a, host_b} this cycle
//   host_ct      1 = command, 0 = data transfer
//   host_a       busA byte
//   host_b       busB byte
//   flush        synchronous: empty the FIFO and abort the current request
//   err_clr      synchronous: clear err_timeout
//   full         FIFO holds DEPTH entries
//   empty        FIFO empty and sequencer idle
//   level        entries stored, including the one in flight
//   err_timeout  sticky flag: a request was aborted
//   _ve          VIN select, active low
//   c_t          command/transfer flag of the presented entry
//   vin_a        busA drive value
//   vin_b        busB drive value
//   vin_oe       1 = drive vin_a/vin_b onto the VIN buses
//   _st          VIN mailbox strobe, active low, asynchronous to this block
module vin_mailbox_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 512,
  parameter int unsigned GAP     = 4
) (
  input  logic                   clk,
  input  logic                   _res,
  input  logic                   host_wr,
  input  logic                   host_ct,
  input  logic [7:0]             host_a,
  input  logic [7:0]             host_b,
  input  logic                   flush,
  input  logic                   err_clr,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_timeout,
  output logic                   _ve,
  output logic                   c_t,
  output logic [7:0]             vin_a,
  output logic [7:0]             vin_b,
  output logic                   vin_oe,
  input  logic                   _st
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned TcntW = $clog2(TIMEOUT);
  localparam int unsigned GcntW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StPresent,
    StAccept,
    StAbort,
    StGap
  } state_e;

  state_e state_q, state_d;

  // Strobe synchroniser; idles high so a reset never looks like a strobe.
  logic st_sync1_q, st_sync2_q;
  logic st_lo;

  // FIFO storage: {ct, a, b}
  logic [16:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [16:0]     head;
  logic            push, pop;

  // Counters and registered VIN-side outputs
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic [GcntW-1:0] gcnt_q, gcnt_d;
  logic             tcnt_last, gcnt_last;
  logic             ve_n_q, ve_n_d;
  logic             oe_q, oe_d;
  logic             ct_q, ct_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic             err_q, err_d;

  assign st_lo     = ~st_sync2_q;
  assign head      = mem_q[rptr_q];
  assign tcnt_last = (tcnt_q == TcntW'(TIMEOUT - 1));
  assign gcnt_last = (gcnt_q == GcntW'(GAP - 1));

  assign full  = (level_q == LvlW'(DEPTH));
  assign empty = (level_q == '0) && (state_q == StIdle);
  assign level = level_q;

  assign err_timeout = err_q;
  assign _ve         = ve_n_q;
  assign c_t         = ct_q;
  assign vin_a       = a_q;
  assign vin_b       = b_q;
  assign vin_oe      = oe_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge _res) begin
    if (!_res) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (level_q != '0) state_d = StPresent;
      end
      StPresent: begin
        if (st_lo)          state_d = StAccept;
        else if (tcnt_last) state_d = StAbort;
      end
      StAccept: begin
        if (!st_lo) state_d = StGap;
      end
      StAbort: begin
        state_d = StGap;
      end
      StGap: begin
        if (gcnt_last) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Flush overrides everything; an idle sequencer simply stays idle.
    if (flush) state_d = (state_q == StIdle) ? StIdle : StGap;
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: next values of the registered VIN pins, counters and pop
  // ---------------------------------------------------------------------------
  always_comb begin
    ve_n_d = ve_n_q;
    oe_d   = oe_q;
    ct_d   = ct_q;
    a_d    = a_q;
    b_d    = b_q;
    tcnt_d = tcnt_q;
    gcnt_d = gcnt_q;
    pop    = 1'b0;
    err_d  = err_q;

    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (state_d == StPresent) begin
          // Buses are loaded once here and held until the entry retires.
          ct_d   = head[16];
          a_d    = head[15:8];
          b_d    = head[7:0];
          oe_d   = 1'b1;
          ve_n_d = 1'b0;
          tcnt_d = '0;
        end
      end
      StPresent: begin
        if (state_d == StPresent) tcnt_d = tcnt_q + TcntW'(1);
      end
      StAccept: begin
        if (state_d == StGap) pop = 1'b1;
      end
      StAbort: begin
        pop   = 1'b1;
        err_d = 1'b1;  // a simultaneous err_clr loses to a fresh abort
      end
      StGap: begin
        if (state_d == StGap) gcnt_d = gcnt_q + GcntW'(1);
      end
      default: ;
    endcase

    // _ve is already released in ABORT so the low phase lasts exactly TIMEOUT cycles.
    if ((state_d == StGap) || (state_d == StAbort)) begin
      ve_n_d = 1'b1;
      oe_d   = 1'b0;
    end
    if ((state_d == StGap) && ((state_q != StGap) || flush)) gcnt_d = '0;
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  always_comb begin
    // A full FIFO still takes a write in the cycle its head retires.
    push    = host_wr && !flush && (!full || pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {host_ct, host_a, host_b};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge _res) begin
    if (!_res) begin
      st_sync1_q <= 1'b1;
      st_sync2_q <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      tcnt_q     <= '0;
      gcnt_q     <= '0;
      ve_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      ct_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      st_sync1_q <= _st;
      st_sync2_q <= st_sync1_q;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      tcnt_q     <= tcnt_d;
      gcnt_q     <= gcnt_d;
      ve_n_q     <= ve_n_d;
      oe_q       <= oe_d;
      ct_q       <= ct_d;
      a_q        <= a_d;
      b_q        <= b_d;
      err_q      <= err_d;
    end
  end

endmodule
